// File: rtl/mem_xfer_ctrl.sv
// rtl/mem_xfer_ctrl.sv - MAR/MDR/memory read-write transaction sequencer
// Optional wait-state timeout abort enabled by defining MEM_TIMEOUT_EN.
module mem_xfer_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic clk,
   input  logic reset_n,
   input  logic req_rd,
   input  logic req_wr,
   input  logic mem_ready,
   output logic busy,
   output logic done,
   output logic err,
   output logic mar_in,
   output logic mdr_in,
   output logic mdr_read,
   output logic mem_rd,
   output logic mem_wr
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_cfg
      $error("CNT_W too narrow for TIMEOUT_CYCLES-1");
   end

`ifdef MEM_TIMEOUT_EN
   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WDATA, S_RD_WAIT, S_WR_WAIT, S_DONE, S_ERR
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WDATA, S_RD_WAIT, S_WR_WAIT, S_DONE
   } state_t;
`endif

   state_t r_state;
   state_t w_next;
   logic   r_is_rd;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_is_rd <= 1'b0;
      end else begin
         r_state <= w_next;
         // Read wins a tie; a simultaneous write is simply dropped.
         if (r_state == S_IDLE && (req_rd || req_wr))
            r_is_rd <= req_rd;
      end
   end

`ifdef MEM_TIMEOUT_EN
   logic [CNT_W-1:0] r_wait_cnt;
   logic             w_wait_st;
   logic             w_timeout;

   assign w_wait_st = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
   assign w_timeout = !mem_ready && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Held at zero outside the wait states, so every wait phase starts from 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_wait_cnt <= '0;
      else if (!w_wait_st)
         r_wait_cnt <= '0;
      else if (!mem_ready && r_wait_cnt != '1)
         r_wait_cnt <= r_wait_cnt + 1'b1;
   end
`else
   assign err = 1'b0;
`endif

   always_comb begin
      w_next   = r_state;
      busy     = 1'b0;
      done     = 1'b0;
`ifdef MEM_TIMEOUT_EN
      err      = 1'b0;
`endif
      mar_in   = 1'b0;
      mdr_in   = 1'b0;
      mdr_read = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_rd || req_wr)
               w_next = S_ADDR;
         end
         S_ADDR: begin
            busy   = 1'b1;
            mar_in = 1'b1;
            w_next = r_is_rd ? S_RD_WAIT : S_WDATA;
         end
         S_WDATA: begin
            busy   = 1'b1;
            mdr_in = 1'b1;
            w_next = S_WR_WAIT;
         end
         S_RD_WAIT: begin
            busy     = 1'b1;
            mem_rd   = 1'b1;
            mdr_read = 1'b1;
            mdr_in   = mem_ready;
            if (mem_ready)
               w_next = S_DONE;
`ifdef MEM_TIMEOUT_EN
            else if (w_timeout)
               w_next = S_ERR;
`endif
         end
         S_WR_WAIT: begin
            busy   = 1'b1;
            mem_wr = 1'b1;
            if (mem_ready)
               w_next = S_DONE;
`ifdef MEM_TIMEOUT_EN
            else if (w_timeout)
               w_next = S_ERR;
`endif
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
`ifdef MEM_TIMEOUT_EN
         S_ERR: begin
            err    = 1'b1;
            w_next = S_IDLE;
         end
`endif
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// tb/tb_mem_xfer_ctrl.sv - directed self-checking bench for mem_xfer_ctrl
module tb_mem_xfer_ctrl;

   logic clk = 1'b0;
   logic reset_n, req_rd, req_wr, mem_ready;
   logic busy, done, err, mar_in, mdr_in, mdr_read, mem_rd, mem_wr;
   logic [7:0] w_outs;
   int n_total = 0;
   int n_bad   = 0;
   int n_wr_cyc = 0;

   // Output vector order: busy done err mar_in mdr_in mdr_read mem_rd mem_wr
   localparam logic [7:0] E_IDLE  = 8'b0000_0000;
   localparam logic [7:0] E_ADDR  = 8'b1001_0000;
   localparam logic [7:0] E_WDATA = 8'b1000_1000;
   localparam logic [7:0] E_RDW   = 8'b1000_0110;
   localparam logic [7:0] E_RDRDY = 8'b1000_1110;
   localparam logic [7:0] E_WRW   = 8'b1000_0001;
   localparam logic [7:0] E_DONE  = 8'b0100_0000;
   localparam logic [7:0] E_ERR   = 8'b0010_0000;

   mem_xfer_ctrl #(
`ifdef MEM_TIMEOUT_EN
      .TIMEOUT_CYCLES(4),
      .CNT_W         (3)
`else
      .TIMEOUT_CYCLES(16),
      .CNT_W         (5)
`endif
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req_rd   (req_rd),
      .req_wr   (req_wr),
      .mem_ready(mem_ready),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .mar_in   (mar_in),
      .mdr_in   (mdr_in),
      .mdr_read (mdr_read),
      .mem_rd   (mem_rd),
      .mem_wr   (mem_wr)
   );

   assign w_outs = {busy, done, err, mar_in, mdr_in, mdr_read, mem_rd, mem_wr};

   always #5 clk = ~clk;

   always @(negedge clk) if (mem_wr) n_wr_cyc++;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic [7:0] exp);
      @(negedge clk);
      chk(tag, w_outs, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int n;
      reset_n = 1'b0; req_rd = 1'b0; req_wr = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", w_outs, E_IDLE);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      // 1: read, ready on 4th wait cycle
      req_rd = 1'b1;
      cyc("t1_c0", E_IDLE);
      cyc("t1_c1_addr", E_ADDR);
      cyc("t1_c2", E_RDW);
      cyc("t1_c3", E_RDW);
      cyc("t1_c4", E_RDW);
      mem_ready = 1'b1;
      cyc("t1_c5_rdy", E_RDRDY);
      mem_ready = 1'b0; req_rd = 1'b0;
      cyc("t1_c6_done", E_DONE);
      cyc("t1_c7_idle", E_IDLE);

      // 2: write, ready in first wait cycle
      req_wr = 1'b1;
      cyc("t2_c0", E_IDLE);
      cyc("t2_c1_addr", E_ADDR);
      cyc("t2_c2_wdata", E_WDATA);
      mem_ready = 1'b1;
      cyc("t2_c3_wr", E_WRW);
      mem_ready = 1'b0; req_wr = 1'b0;
      cyc("t2_c4_done", E_DONE);
      cyc("t2_c5_idle", E_IDLE);
      chk("t2_wr_cycles", 8'(n_wr_cyc), 8'd1);

      // 3: simultaneous requests, read wins
      req_rd = 1'b1; req_wr = 1'b1;
      cyc("t3_c0", E_IDLE);
      cyc("t3_c1_addr", E_ADDR);
      mem_ready = 1'b1;
      cyc("t3_c2_rdy", E_RDRDY);
      mem_ready = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
      cyc("t3_c3_done", E_DONE);
      cyc("t3_c4_idle", E_IDLE);
      chk("t3_no_write", 8'(n_wr_cyc), 8'd1);

      // 4: async reset during RD_WAIT
      req_rd = 1'b1;
      cyc("t4_c0", E_IDLE);
      cyc("t4_c1_addr", E_ADDR);
      cyc("t4_c2", E_RDW);
      #2 reset_n = 1'b0; req_rd = 1'b0;
      #1 chk("t4_async_drop", w_outs, E_IDLE);
      @(negedge clk);
      chk("t4_in_reset", w_outs, E_IDLE);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      req_rd = 1'b1;
      cyc("t4_r_c0", E_IDLE);
      cyc("t4_r_addr", E_ADDR);
      mem_ready = 1'b1;
      cyc("t4_r_rdy", E_RDRDY);
      mem_ready = 1'b0; req_rd = 1'b0;
      cyc("t4_r_done", E_DONE);
      cyc("t4_r_idle", E_IDLE);

      // 5: no ready from memory
      req_rd = 1'b1;
      cyc("t5_c0", E_IDLE);
      cyc("t5_c1_addr", E_ADDR);
`ifdef MEM_TIMEOUT_EN
      cyc("t5_w0", E_RDW);
      cyc("t5_w1", E_RDW);
      cyc("t5_w2", E_RDW);
      cyc("t5_w3", E_RDW);
      req_rd = 1'b0;
      cyc("t5_err", E_ERR);
      cyc("t5_idle", E_IDLE);
      // ready on the final allowed wait cycle beats the timeout
      req_wr = 1'b1;
      cyc("t5b_c0", E_IDLE);
      cyc("t5b_addr", E_ADDR);
      cyc("t5b_wdata", E_WDATA);
      cyc("t5b_w0", E_WRW);
      cyc("t5b_w1", E_WRW);
      cyc("t5b_w2", E_WRW);
      mem_ready = 1'b1;
      cyc("t5b_w3_rdy", E_WRW);
      mem_ready = 1'b0; req_wr = 1'b0;
      cyc("t5b_done", E_DONE);
      cyc("t5b_idle", E_IDLE);
`else
      n = 0;
      repeat (100) begin
         @(negedge clk);
         if (mem_rd && busy && !err) n++;
      end
      chk("t5_hold_100", 8'(n), 8'd100);
      @(posedge clk); #1;
      mem_ready = 1'b1;
      cyc("t5_rdy", E_RDRDY);
      mem_ready = 1'b0; req_rd = 1'b0;
      cyc("t5_done", E_DONE);
      cyc("t5_idle", E_IDLE);
`endif

      // 6: stray mem_ready in IDLE, req_wr only during DONE
      n = n_wr_cyc;
      mem_ready = 1'b1;
      cyc("t6_idle_rdy0", E_IDLE);
      cyc("t6_idle_rdy1", E_IDLE);
      mem_ready = 1'b0;
      req_rd = 1'b1;
      cyc("t6_c0", E_IDLE);
      cyc("t6_addr", E_ADDR);
      mem_ready = 1'b1;
      cyc("t6_rdy", E_RDRDY);
      mem_ready = 1'b0; req_rd = 1'b0; req_wr = 1'b1;
      cyc("t6_done", E_DONE);
      req_wr = 1'b0;
      cyc("t6_idle0", E_IDLE);
      cyc("t6_idle1", E_IDLE);
      chk("t6_no_write", 8'(n_wr_cyc), 8'(n));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
